// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the CPU-to-async-memory bus controller.
package mem_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] ADDR_LAST = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        WR_SETUP  = 3'd2,
        WR_STROBE = 3'd3,
        WR_HOLD   = 3'd4,
        RESP      = 3'd5
    } state_t;

    function automatic logic [DATA_W-1:0] swapBytes(input logic [DATA_W-1:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU request/response handshake plus the asynchronous memory pins.
interface mem_bus_ctrl_if;
    import mem_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] memAddr;
    logic              memRe;
    logic              memWe;
    logic [DATA_W-1:0] memWBus;
    logic [DATA_W-1:0] memRBus;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, memRBus,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, memAddr, memRe, memWe, memWBus
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, memRBus,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, memAddr, memRe, memWe, memWBus
    );

endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding bus stage driving an asynchronous 16-bit memory with
// registered strobes, a programmable read settle time and write byte normalisation.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned RD_WAIT       = 1,
    parameter int unsigned WE_WIDTH      = 1,
    parameter int unsigned SWAP_WR_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_bus_ctrl_if.slave bus
);

    generate
        if (RD_WAIT > 32'd15) begin : gRdWaitRange
            $fatal(1, "mem_bus_ctrl: RD_WAIT must be 0..15");
        end
        if ((WE_WIDTH < 32'd1) || (WE_WIDTH > 32'd15)) begin : gWeWidthRange
            $fatal(1, "mem_bus_ctrl: WE_WIDTH must be 1..15");
        end
        if (SWAP_WR_BYTES > 32'd1) begin : gSwapRange
            $fatal(1, "mem_bus_ctrl: SWAP_WR_BYTES must be 0 or 1");
        end
    endgenerate

    localparam logic [3:0] RD_CNT_INIT = 4'(RD_WAIT);
    localparam logic [3:0] WE_CNT_INIT = 4'(WE_WIDTH - 32'd1);

    state_t            stateR, nextStateS;
    logic [3:0]        cntR, cntS;
    logic              idleR, idleS;
    logic              rspValidR, rspValidS;
    logic [DATA_W-1:0] rspRdataR, rspRdataS;
    logic              rspErrR, rspErrS;
    logic [ADDR_W-1:0] memAddrR, memAddrS;
    logic              memReR, memReS;
    logic              memWeR, memWeS;
    logic [DATA_W-1:0] memWBusR, memWBusS;
    logic [DATA_W-1:0] wdataMapS;
    logic              reqReadyS;
    logic              acceptS;

    // idleR is 0 through reset so the core cannot hand over a request before the first clock.
    assign reqReadyS = idleR || ((stateR == RESP) && bus.rsp_ready);
    assign acceptS   = bus.req_valid && reqReadyS;
    assign wdataMapS = (SWAP_WR_BYTES != 32'd0) ? swapBytes(bus.req_wdata) : bus.req_wdata;

    // Next-state and next-output computation for every registered output.
    always_comb begin
        nextStateS = stateR;
        cntS       = cntR;
        rspValidS  = rspValidR;
        rspRdataS  = rspRdataR;
        rspErrS    = rspErrR;
        memAddrS   = memAddrR;
        memReS     = memReR;
        memWeS     = memWeR;
        memWBusS   = memWBusR;

        case (stateR)
            IDLE, RESP: begin
                if ((stateR == RESP) && bus.rsp_ready) begin
                    rspValidS  = 1'b0;
                    nextStateS = IDLE;
                end else begin
                    rspValidS  = rspValidR;
                end
                if (acceptS) begin
                    rspErrS = 1'b0;
                    if (bus.req_addr == ADDR_LAST) begin
                        // Word at the top byte would wrap; answer without touching memory.
                        nextStateS = RESP;
                        rspValidS  = 1'b1;
                        rspErrS    = 1'b1;
                        rspRdataS  = 16'h0000;
                    end else if (bus.req_we) begin
                        memAddrS   = bus.req_addr;
                        memWBusS   = wdataMapS;
                        memWeS     = 1'b0;
                        nextStateS = WR_SETUP;
                    end else begin
                        memAddrS   = bus.req_addr;
                        memReS     = 1'b1;
                        cntS       = RD_CNT_INIT;
                        nextStateS = RD_ACCESS;
                    end
                end else begin
                    memReS = 1'b0;
                    memWeS = 1'b0;
                end
            end
            RD_ACCESS: begin
                if (cntR == 4'd0) begin
                    rspRdataS  = bus.memRBus;
                    memReS     = 1'b0;
                    rspValidS  = 1'b1;
                    nextStateS = RESP;
                end else begin
                    cntS = cntR - 4'd1;
                end
            end
            WR_SETUP: begin
                memWeS     = 1'b1;
                cntS       = WE_CNT_INIT;
                nextStateS = WR_STROBE;
            end
            WR_STROBE: begin
                if (cntR == 4'd0) begin
                    memWeS     = 1'b0;
                    nextStateS = WR_HOLD;
                end else begin
                    cntS = cntR - 4'd1;
                end
            end
            WR_HOLD: begin
                rspValidS  = 1'b1;
                rspRdataS  = 16'h0000;
                nextStateS = RESP;
            end
            default: begin
                memReS     = 1'b0;
                memWeS     = 1'b0;
                nextStateS = IDLE;
            end
        endcase

        idleS = (nextStateS == IDLE);
    end

    // State and output registers; reset drops the strobes asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR    <= IDLE;
            cntR      <= 4'd0;
            idleR     <= 1'b0;
            rspValidR <= 1'b0;
            rspRdataR <= 16'h0000;
            rspErrR   <= 1'b0;
            memAddrR  <= 16'h0000;
            memReR    <= 1'b0;
            memWeR    <= 1'b0;
            memWBusR  <= 16'h0000;
        end else begin
            stateR    <= nextStateS;
            cntR      <= cntS;
            idleR     <= idleS;
            rspValidR <= rspValidS;
            rspRdataR <= rspRdataS;
            rspErrR   <= rspErrS;
            memAddrR  <= memAddrS;
            memReR    <= memReS;
            memWeR    <= memWeS;
            memWBusR  <= memWBusS;
        end
    end

    assign bus.req_ready = reqReadyS;
    assign bus.rsp_valid = rspValidR;
    assign bus.rsp_rdata = rspRdataR;
    assign bus.rsp_err   = rspErrR;
    assign bus.memAddr   = memAddrR;
    assign bus.memRe     = memReR;
    assign bus.memWe     = memWeR;
    assign bus.memWBus   = memWBusR;

endmodule
